// File: rtl/qcldpc_pkg.sv
// Shared constants, state codes and ROM addressing helper for the QC-LDPC encoder.
package qcldpc_pkg;

  localparam int unsigned DEF_NUM_Z         = 3;
  localparam int unsigned DEF_NUM_INFO_BLKS = 20;
  localparam int unsigned DEF_NUM_PAR_BLKS  = 4;
  localparam int unsigned DEF_DP_LAT        = 1;

  localparam int unsigned ROW_LEN    = DEF_NUM_INFO_BLKS + DEF_NUM_PAR_BLKS;
  localparam int unsigned Z_IDX_W    = $clog2(DEF_NUM_Z);
  localparam int unsigned COL_W      = $clog2(DEF_NUM_INFO_BLKS);
  localparam int unsigned PAR_W      = $clog2(DEF_NUM_PAR_BLKS);
  localparam int unsigned ROM_ADDR_W = $clog2(DEF_NUM_Z * ROW_LEN);
  localparam int unsigned LAT_W      = 3;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CLEAR  = 3'd1;
  localparam state_t S_STREAM = 3'd2;
  localparam state_t S_DRAIN  = 3'd3;
  localparam state_t S_PARITY = 3'd4;
  localparam state_t S_OUTPUT = 3'd5;

  // First shift-ROM row of the bank belonging to lifting size z.
  function automatic logic [ROM_ADDR_W-1:0] rom_row_base(input logic [Z_IDX_W-1:0] z);
    return ROM_ADDR_W'(z) * ROM_ADDR_W'(ROW_LEN);
  endfunction

endpackage

// File: rtl/qcldpc_encode_sequencer_onehot_to_idx.sv
// One-hot to binary index converter with a one-hot validity flag.
module onehot_to_idx #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]                         onehot,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx,
  output logic                                 valid
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

  assign valid = $onehot(onehot);

endmodule

// File: rtl/qcldpc_encode_sequencer.sv
// Codeword sequencer for the QC-LDPC encoder: config latch, column streaming,
// parity resolution scheduling and parity block hand-off.
module qcldpc_encode_sequencer
  import qcldpc_pkg::*;
#(
  parameter int unsigned NUM_Z         = DEF_NUM_Z,
  parameter int unsigned NUM_INFO_BLKS = DEF_NUM_INFO_BLKS,
  parameter int unsigned NUM_PAR_BLKS  = DEF_NUM_PAR_BLKS,
  parameter int unsigned DP_LAT        = DEF_DP_LAT
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   cfg_valid,
  input  logic [NUM_Z-1:0]                                       cfg_z_sel,
  output logic                                                   cfg_ready,
  output logic                                                   cfg_err,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic                                                   abort,
  output logic [$clog2(NUM_Z)-1:0]                               z_idx,
  output logic [$clog2(NUM_Z*(NUM_INFO_BLKS+NUM_PAR_BLKS))-1:0]  rom_addr,
  output logic                                                   col_en,
  output logic                                                   acc_clr,
  output logic                                                   par_en,
  output logic [$clog2(NUM_PAR_BLKS)-1:0]                        par_idx,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic                                                   out_last,
  output logic                                                   busy
);

  localparam int unsigned ZW    = $clog2(NUM_Z);
  localparam int unsigned CW    = $clog2(NUM_INFO_BLKS);
  localparam int unsigned PW    = $clog2(NUM_PAR_BLKS);
  localparam int unsigned ROW   = NUM_INFO_BLKS + NUM_PAR_BLKS;
  localparam int unsigned ROM_W = $clog2(NUM_Z * ROW);

  localparam logic [CW-1:0] LAST_COL = CW'(NUM_INFO_BLKS - 1);
  localparam logic [PW-1:0] LAST_PAR = PW'(NUM_PAR_BLKS - 1);

  state_t             state, state_n;
  logic [CW-1:0]      col_cnt, col_n;
  logic [LAT_W-1:0]   lat_cnt, lat_n;
  logic [PW-1:0]      par_cnt, par_n;
  logic [ZW-1:0]      z_n;
  logic               err_n;
  logic               abort_hit;
  logic [ROM_W-1:0]   rom_n;
  logic [ROM_W-1:0]   row_base;
  logic [ZW-1:0]      oh_idx;
  logic               oh_valid;

  onehot_to_idx #(.N(NUM_Z)) u_onehot (
    .onehot (cfg_z_sel),
    .idx    (oh_idx),
    .valid  (oh_valid)
  );

  // Next state and counter updates; abort outranks every handshake.
  always_comb begin
    state_n   = state;
    col_n     = col_cnt;
    lat_n     = lat_cnt;
    par_n     = par_cnt;
    z_n       = z_idx;
    err_n     = 1'b0;
    abort_hit = 1'b0;
    if (abort && (state != S_IDLE)) begin
      state_n   = S_IDLE;
      col_n     = '0;
      lat_n     = '0;
      par_n     = '0;
      abort_hit = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            if (oh_valid) begin
              z_n     = oh_idx;
              state_n = S_CLEAR;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        S_CLEAR: begin
          col_n   = '0;
          state_n = S_STREAM;
        end
        S_STREAM: begin
          if (in_valid) begin
            if (col_cnt == LAST_COL) begin
              col_n   = '0;
              state_n = (DP_LAT == 0) ? S_PARITY : S_DRAIN;
            end else begin
              col_n = col_cnt + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if ((32'(lat_cnt) + 32'd1) >= DP_LAT) begin
            lat_n   = '0;
            state_n = S_PARITY;
          end else begin
            lat_n = lat_cnt + LAT_W'(1);
          end
        end
        S_PARITY: begin
          if (par_cnt == LAST_PAR) begin
            par_n   = '0;
            state_n = S_OUTPUT;
          end else begin
            par_n = par_cnt + PW'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (par_cnt == LAST_PAR) begin
              par_n   = '0;
              state_n = S_IDLE;
            end else begin
              par_n = par_cnt + PW'(1);
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // ROM row for the upcoming cycle, so rom_addr lines up with the beat.
  always_comb begin
    row_base = ROM_W'(z_n) * ROM_W'(ROW);
    rom_n    = '0;
    case (state_n)
      S_STREAM: rom_n = row_base + ROM_W'(col_n);
      S_PARITY: rom_n = row_base + ROM_W'(NUM_INFO_BLKS) + ROM_W'(par_n);
      default:  rom_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      col_cnt   <= '0;
      lat_cnt   <= '0;
      par_cnt   <= '0;
      z_idx     <= '0;
      rom_addr  <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      in_ready  <= 1'b0;
      acc_clr   <= 1'b0;
      par_en    <= 1'b0;
      par_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      col_cnt   <= col_n;
      lat_cnt   <= lat_n;
      par_cnt   <= par_n;
      z_idx     <= z_n;
      rom_addr  <= rom_n;
      cfg_ready <= (state_n == S_IDLE);
      cfg_err   <= err_n;
      in_ready  <= (state_n == S_STREAM);
      acc_clr   <= (state_n == S_CLEAR) || abort_hit;
      par_en    <= (state_n == S_PARITY);
      par_idx   <= par_n;
      out_valid <= (state_n == S_OUTPUT);
      out_last  <= (state_n == S_OUTPUT) && (par_n == LAST_PAR);
      busy      <= (state_n != S_IDLE);
    end
  end

  // The only combinational input-to-output path: the column beat itself.
  assign col_en = in_valid & in_ready;

endmodule

// File: tb/tb_qcldpc_encode_sequencer.sv
// Scoreboard bench for qcldpc_encode_sequencer: expected datapath strobes are
// queued by the stimulus and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_qcldpc_encode_sequencer;

  localparam int NI   = 20;
  localparam int NP   = 4;
  localparam int DLAT = 1;
  localparam int ROWL = NI + NP;

  localparam int EV_COL = 0;
  localparam int EV_PAR = 1;
  localparam int EV_OUT = 2;
  localparam int EV_CLR = 3;
  localparam int EV_ERR = 4;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [2:0] cfg_z_sel;
  logic       cfg_ready;
  logic       cfg_err;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic [1:0] z_idx;
  logic [6:0] rom_addr;
  logic       col_en;
  logic       acc_clr;
  logic       par_en;
  logic [1:0] par_idx;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  ev_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  busy_cycles = 0;

  qcldpc_encode_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_z_sel (cfg_z_sel),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .z_idx     (z_idx),
    .rom_addr  (rom_addr),
    .col_en    (col_en),
    .acc_clr   (acc_clr),
    .par_en    (par_en),
    .par_idx   (par_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  task automatic pop_check(input int kind, input int a, input int b, input string name);
    ev_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event a=%0d b=%0d, expected none", name, a, b);
    end else begin
      e = q.pop_front();
      check({name, " kind"}, kind, e.kind);
      check({name, " a"}, a, e.a);
      check({name, " b"}, b, e.b);
    end
  endtask

  // Monitor: every datapath strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cycles++;
      if (cfg_err) pop_check(EV_ERR, 0, 0, "cfg_err");
      if (acc_clr) pop_check(EV_CLR, 0, 0, "acc_clr");
      if (!abort) begin
        if (col_en) pop_check(EV_COL, int'(z_idx), int'(rom_addr), "col_beat");
        if (par_en) pop_check(EV_PAR, int'(par_idx), int'(rom_addr), "par_step");
        if (out_valid && out_ready) pop_check(EV_OUT, int'(par_idx), int'(out_last), "out_blk");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sel_to_z(input logic [2:0] sel);
    int z = 0;
    for (int i = 0; i < 3; i++) if (sel[i]) z = i;
    return z;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " cfg_ready"}, int'(cfg_ready), 1);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " in_ready"}, int'(in_ready), 0);
    check({tag, " par_en"}, int'(par_en), 0);
    check({tag, " out_valid"}, int'(out_valid), 0);
  endtask

  task automatic send_cfg(input logic [2:0] sel);
    int g = 0;
    cfg_valid = 1'b1;
    cfg_z_sel = sel;
    while (!cfg_ready && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) timeout("cfg_ready");
    if ($onehot(sel)) q.push_back('{EV_CLR, 0, 0});
    else              q.push_back('{EV_ERR, 0, 0});
    tick();
    cfg_valid = 1'b0;
    cfg_z_sel = '0;
  endtask

  task automatic after_abort();
    check("abort busy", int'(busy), 0);
    check("abort acc_clr", int'(acc_clr), 1);
    check("abort cfg_ready", int'(cfg_ready), 1);
    tick();
    check("abort acc_clr once", int'(acc_clr), 0);
    repeat (5) tick();
    check("abort col_en", int'(col_en), 0);
    check("abort par_en", int'(par_en), 0);
  endtask

  // One codeword. iv_mode: 0 back-to-back, 1 toggle, 2 random.
  task automatic run_cw(input logic [2:0] sel, input int iv_mode, input int or_rand,
                        input int stall_idx, input int abort_beat, input int abort_par);
    int z;
    int beats;
    int g;
    int hs;
    bit stalled;
    bit just_stalled;
    z = sel_to_z(sel);
    send_cfg(sel);
    check("accept busy", int'(busy), 1);
    check("accept z_idx", int'(z_idx), z);
    beats = 0;
    g = 0;
    while (beats < NI && g < 2000) begin
      case (iv_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((g % 2) == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (in_valid && in_ready) begin
        if (abort_beat == beats + 1) begin
          abort = 1'b1;
          q.push_back('{EV_CLR, 0, 0});
          tick();
          abort = 1'b0;
          in_valid = 1'b0;
          after_abort();
          return;
        end
        q.push_back('{EV_COL, z, z * ROWL + beats});
        beats++;
      end
      tick();
      g++;
    end
    in_valid = 1'b0;
    if (g >= 2000) timeout("stream");
    if (abort_par >= 0) begin
      for (int p = 0; p < abort_par; p++) q.push_back('{EV_PAR, p, z * ROWL + NI + p});
    end else begin
      for (int p = 0; p < NP; p++) q.push_back('{EV_PAR, p, z * ROWL + NI + p});
    end
    for (int i = 0; i < DLAT; i++) begin
      check("drain in_ready", int'(in_ready), 0);
      check("drain par_en", int'(par_en), 0);
      check("drain busy", int'(busy), 1);
      tick();
    end
    check("parity start", int'(par_en), 1);
    if (abort_par >= 0) begin
      repeat (abort_par) tick();
      abort = 1'b1;
      q.push_back('{EV_CLR, 0, 0});
      tick();
      abort = 1'b0;
      after_abort();
      return;
    end
    repeat (NP) tick();
    for (int p = 0; p < NP; p++) q.push_back('{EV_OUT, p, (p == NP - 1) ? 1 : 0});
    hs = 0;
    g = 0;
    stalled = 1'b0;
    while (hs < NP && g < 2000) begin
      just_stalled = 1'b0;
      out_ready = or_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_idx >= 0 && !stalled && out_valid && int'(par_idx) == stall_idx) begin
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick();
          check("stall out_valid", int'(out_valid), 1);
          check("stall par_idx", int'(par_idx), stall_idx);
        end
        stalled = 1'b1;
        just_stalled = 1'b1;
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) hs++;
      tick();
      g++;
      if (just_stalled) check("stall release par_idx", int'(par_idx), stall_idx + 1);
    end
    out_ready = 1'b0;
    if (g >= 2000) timeout("output");
    check_idle_outputs("end");
  endtask

  initial begin
    int start;
    logic [2:0] sel;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_z_sel = '0;
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset rom_addr", int'(rom_addr), 0);
    check("reset z_idx", int'(z_idx), 0);
    check("reset acc_clr", int'(acc_clr), 0);
    check("reset cfg_err", int'(cfg_err), 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of STREAM after 7 beats.
    begin
      int beats = 0;
      int g = 0;
      send_cfg(3'b100);
      in_valid = 1'b1;
      while (beats < 7 && g < 100) begin
        if (in_ready) begin
          q.push_back('{EV_COL, 2, 2 * ROWL + beats});
          beats++;
        end
        tick();
        g++;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_idle_outputs("midreset");
      check("midreset rom_addr", int'(rom_addr), 0);
      check("midreset z_idx", int'(z_idx), 0);
      check("midreset col_en", int'(col_en), 0);
      check("midreset out_last", int'(out_last), 0);
      q.delete();
      #2;
      rst = 1'b0;
      tick();
    end
    run_cw(3'b010, 0, 0, -1, 0, -1);

    // Nominal codeword with busy duration.
    start = busy_cycles;
    run_cw(3'b100, 0, 0, -1, 0, -1);
    check("nominal busy cycles", busy_cycles - start, 1 + NI + DLAT + NP + NP);

    run_cw(3'b001, 1, 0, -1, 0, -1);

    send_cfg(3'b011);
    check("err busy", int'(busy), 0);
    check("err cfg_ready", int'(cfg_ready), 1);
    send_cfg(3'b000);
    check("err2 busy", int'(busy), 0);
    tick();
    check("err single pulse", int'(cfg_err), 0);

    run_cw(3'b001, 0, 0, 1, 0, -1);
    run_cw(3'b010, 0, 0, -1, 10, -1);
    run_cw(3'b100, 0, 0, -1, 0, 2);

    for (int i = 0; i < 6; i++) begin
      sel = 3'(1 << $urandom_range(0, 2));
      run_cw(sel, 2, 1, -1, 0, -1);
    end

    repeat (5) tick();
    check("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
